// File: rtl/sr_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// sr_pulse_sequencer
//   Drives the active-low set/reset lines of an external cross-coupled NAND
//   SR latch. Every pulse is held low for exactly PULSE_W cycles, followed by
//   GAP_W cycles with both lines high, then the synchronized latch output is
//   compared against the requested value.
//
// Ports:
//   clk        - single rising-edge clock
//   reset0     - synchronous active-low reset
//   set_req    - request latch q=1 (held by requester until granted)
//   rst_req    - request latch q=0 (held by requester until granted)
//   req_ready  - high in IDLE; request accepted on edge with req && req_ready
//   grant_set  - high during the accept cycle of a set request
//   grant_rst  - high during the accept cycle of a reset request
//   latch_set0 - registered active-low set line to the latch
//   latch_rst0 - registered active-low reset line to the latch
//   latch_q    - latch output, asynchronous to clk
//   busy       - high in PULSE, GAP and CHECK
//   done       - 1-cycle completion pulse
//   err        - qualified by done; synchronized q missed the target
// ---------------------------------------------------------------------------
module sr_pulse_sequencer #(
    parameter int PULSE_W     = 3,
    parameter int GAP_W       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset0,
    input  logic set_req,
    input  logic rst_req,
    output logic req_ready,
    output logic grant_set,
    output logic grant_rst,
    output logic latch_set0,
    output logic latch_rst0,
    input  logic latch_q,
    output logic busy,
    output logic done,
    output logic err
);

    // Configuration guard: out-of-range parameters stop elaboration.
    if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse_w
        $error("sr_pulse_sequencer: PULSE_W=%0d outside 1..15", PULSE_W);
    end
    if (GAP_W < 1 || GAP_W > 15 || GAP_W < SYNC_STAGES) begin : g_bad_gap_w
        $error("sr_pulse_sequencer: GAP_W=%0d outside 1..15 or below SYNC_STAGES", GAP_W);
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("sr_pulse_sequencer: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
    end

    typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       target_q, target_d;      // 1 = drive q to 1
    logic       prio_set_q, prio_set_d;  // 1 = set wins the next conflict
    logic       set0_q, set0_d;
    logic       rst0_q, rst0_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       ready_q, ready_d;

    // Synchronizer on the asynchronous latch output. No reset: it only
    // tracks the pin and settles within SYNC_STAGES cycles.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   q_sync;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], latch_q};
    end
    assign q_sync = sync_q[SYNC_STAGES-1];

    // Arbitration: a lone request wins; on conflict the side not granted
    // last wins. Grants are combinational so the requester can drop its
    // request on the very edge that accepts it.
    logic pick_set;
    assign pick_set  = set_req && (!rst_req || prio_set_q);
    assign grant_set = ready_q && pick_set;
    assign grant_rst = ready_q && rst_req && !pick_set;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        prio_set_d = prio_set_q;
        set0_d     = 1'b1;
        rst0_d     = 1'b1;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ready_d    = ready_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (grant_set || grant_rst) begin
                    prio_set_d = grant_rst;
                    target_d   = grant_set;
                    if (grant_set == q_sync) begin
                        // Latch already holds the target: skip the pulse.
                        done_d = 1'b1;
                    end else begin
                        state_d = PULSE;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = 4'(PULSE_W - 1);
                        set0_d  = !grant_set;
                        rst0_d  = grant_set;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = GAP;
                    cnt_d   = 4'(GAP_W - 1);
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    set0_d = !target_q;
                    rst0_d = target_q;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) begin
                    // done/err are registered, so they appear in the CHECK cycle.
                    state_d = CHECK;
                    done_d  = 1'b1;
                    err_d   = (q_sync != target_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset0) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            target_q   <= 1'b0;
            prio_set_q <= 1'b0;
            set0_q     <= 1'b1;
            rst0_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            prio_set_q <= prio_set_d;
            set0_q     <= set0_d;
            rst0_q     <= rst0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    assign latch_set0 = set0_q;
    assign latch_rst0 = rst0_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign req_ready  = ready_q;

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sr_pulse_sequencer
//   Bench for sr_pulse_sequencer with a behavioural NAND SR latch (1-cycle
//   gate delay). Expected completions (cycle and err) are queued when a grant
//   is observed and matched against done pulses by a monitor.
// ---------------------------------------------------------------------------
module tb_sr_pulse_sequencer;
    localparam int P = 3;
    localparam int G = 2;

    logic clk = 1'b0;
    logic reset0 = 1'b0;
    logic set_req = 1'b0, rst_req = 1'b0;
    logic req_ready, grant_set, grant_rst, latch_set0, latch_rst0;
    logic busy, done, err;
    logic lq = 1'b0, lqb = 1'b1;
    logic stuck = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int   at;
        logic err;
    } exp_t;
    exp_t sbq[$];

    sr_pulse_sequencer #(.PULSE_W(P), .GAP_W(G), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset0(reset0), .set_req(set_req), .rst_req(rst_req),
        .req_ready(req_ready), .grant_set(grant_set), .grant_rst(grant_rst),
        .latch_set0(latch_set0), .latch_rst0(latch_rst0), .latch_q(lq),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // NAND latch, one clock of gate delay per gate.
    always @(posedge clk) begin
        if (stuck) begin
            lq  <= 1'b0;
            lqb <= 1'b1;
        end else begin
            lq  <= ~(latch_set0 & lqb);
            lqb <= ~(latch_rst0 & lq);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: line safety every cycle, done pulses against the scoreboard.
    always @(negedge clk) begin
        chk("never_both_low", {31'd0, ~latch_set0 & ~latch_rst0}, 0);
        if (done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", cyc, e.at);
                chk("done_err", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for its grant, then check the line timing.
    task automatic run_op(input bit is_set, input bit pulse, input bit exp_err);
        bit   got;
        exp_t e;
        got = 0;
        @(posedge clk); #1;
        if (is_set) set_req = 1'b1; else rst_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_set ? grant_set : grant_rst) got = 1;
        end
        chk("grant_seen", {31'd0, got}, 1);
        if (got) begin
            e.at  = cyc + 1 + (pulse ? P + G : 0);
            e.err = exp_err;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        set_req = 1'b0;
        rst_req = 1'b0;
        if (got && pulse) begin
            for (int k = 1; k <= P + G + 1; k++) begin
                @(negedge clk);
                chk(is_set ? "set0_pulse" : "rst0_pulse",
                    {31'd0, is_set ? latch_set0 : latch_rst0}, (k <= P) ? 0 : 1);
                chk("other_line_high", {31'd0, is_set ? latch_rst0 : latch_set0}, 1);
                chk("busy_in_op", {31'd0, busy}, 1);
                chk("ready_in_op", {31'd0, req_ready}, 0);
            end
        end
        @(negedge clk);
        chk("ready_after", {31'd0, req_ready}, 1);
        chk("busy_after", {31'd0, busy}, 0);
        chk("set0_idle", {31'd0, latch_set0}, 1);
        chk("rst0_idle", {31'd0, latch_rst0}, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset0 = 1'b0;
        idle(3);
        reset0 = 1'b1;
        @(negedge clk);
        chk("ready_before_release_edge", {31'd0, req_ready}, 0);
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   gs, gr, first_rst;
        exp_t e;
        // Reset state.
        idle(3);
        @(negedge clk);
        chk("rst_set0", {31'd0, latch_set0}, 1);
        chk("rst_rst0", {31'd0, latch_rst0}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_ready", {31'd0, req_ready}, 0);
        @(posedge clk); #1;
        reset0 = 1'b1;
        @(negedge clk);
        chk("ready_before_release_edge", {31'd0, req_ready}, 0);
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 1);

        // 1: set from q=0, full pulse.
        run_op(1, 1, 0);
        chk("t1_latch_q", {31'd0, lq}, 1);
        // 2: reset from q=1, full pulse.
        run_op(0, 1, 0);
        chk("t2_latch_q", {31'd0, lq}, 0);

        // 3: conflict right after reset -> reset first, then set.
        do_reset();
        @(posedge clk); #1;
        set_req = 1'b1;
        rst_req = 1'b1;
        gs = 0; gr = 0; first_rst = 0;
        for (int i = 0; i < 60 && !(gs && gr); i++) begin
            @(negedge clk);
            chk("no_dual_grant", {31'd0, grant_set & grant_rst}, 0);
            if (grant_rst && rst_req) begin
                gr = 1;
                if (!gs) first_rst = 1;
                e.at = cyc + 1; e.err = 0;        // q already 0: no pulse
                sbq.push_back(e);
                @(posedge clk); #1;
                rst_req = 1'b0;
            end else if (grant_set && set_req) begin
                gs = 1;
                e.at = cyc + 1 + P + G; e.err = 0;
                sbq.push_back(e);
                @(posedge clk); #1;
                set_req = 1'b0;
            end
        end
        chk("t3_first_is_rst", {31'd0, first_rst}, 1);
        chk("t3_both_granted", {30'd0, gs, gr}, 3);
        idle(P + G + 3);
        chk("t3_latch_q", {31'd0, lq}, 1);

        // 4: set with q already 1 -> immediate done, no pulse.
        run_op(1, 0, 0);

        // 5: latch stuck at 0 -> err reported.
        stuck = 1'b1;
        idle(4);
        run_op(1, 1, 1);
        stuck = 1'b0;
        idle(3);

        // 6: reset during the second pulse cycle of a set.
        @(posedge clk); #1;
        set_req = 1'b1;
        gs = 0;
        for (int i = 0; i < 20 && !gs; i++) begin
            @(negedge clk);
            if (grant_set) gs = 1;
        end
        chk("t6_grant", {31'd0, gs}, 1);
        @(posedge clk); #1;                        // pulse cycle 1
        set_req = 1'b0;
        @(negedge clk);
        chk("t6_set0_low", {31'd0, latch_set0}, 0);
        @(posedge clk); #1;                        // pulse cycle 2
        reset0 = 1'b0;
        @(negedge clk);
        chk("t6_set0_low_c2", {31'd0, latch_set0}, 0);
        @(negedge clk);                            // after the reset edge
        chk("t6_set0_cut", {31'd0, latch_set0}, 1);
        chk("t6_rst0", {31'd0, latch_rst0}, 1);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_done", {31'd0, done}, 0);
        chk("t6_ready", {31'd0, req_ready}, 0);
        #1;
        reset0 = 1'b1;
        @(negedge clk);
        chk("t6_ready_back", {31'd0, req_ready}, 1);
        idle(4);
        run_op(1, 0, 0);                           // truncated pulse still set q=1
        idle(3);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_pulse_sequencer.md
Name: sr_pulse_sequencer

Overview:
- Synchronous controller that drives the active-low set/reset inputs of an external cross-coupled NAND SR latch.
- Guarantees every set/reset pulse meets a minimum width and is followed by a recovery gap. This prevents the too-short pulses and simultaneous-assert conditions that leave the latch undefined or oscillating.
- Arbitrates between set and reset requesters, then confirms the latch's q output reached the requested value.
- Sits between control logic and any SR-latch storage element.

Parameters:
- PULSE_W, 3: latch line low time in clk cycles; legal range 1..15; must exceed the latch's two-gate propagation delay.
- GAP_W, 2: cycles with both latch lines high after a pulse; legal range 1..15; must be >= SYNC_STAGES.
- SYNC_STAGES, 2: synchronizer flops on latch_q; legal range 2..4.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset0  in  1  synchronous active-low reset.
- set_req  in  1  request to drive latch to q=1; held until accepted.
- rst_req  in  1  request to drive latch to q=0; held until accepted.
- req_ready  out  1  high only in IDLE; a request is accepted on a clock edge where req && req_ready.
- grant_set  out  1  1-cycle pulse on the accept edge when set_req was granted.
- grant_rst  out  1  1-cycle pulse on the accept edge when rst_req was granted.
- latch_set0  out  1  active-low set line to latch; registered.
- latch_rst0  out  1  active-low reset line to latch; registered.
- latch_q  in  1  latch output; asynchronous to clk.
- busy  out  1  high in PULSE, GAP and CHECK.
- done  out  1  1-cycle pulse when an operation completes.
- err  out  1  valid only with done; 1 means synchronized q did not match the target.

Behaviour:
- Reset values (reset0 low at a clock edge): latch_set0=1, latch_rst0=1, busy=0, done=0, err=0, grant_*=0, req_ready=0, state=IDLE, priority=reset-first.
- req_ready rises on the first edge after reset0 returns high.
- latch_set0 and latch_rst0 are never both 0, in any state or under any reset timing. Both are flop outputs, so there are no glitches.
- latch_q passes through SYNC_STAGES flops, giving q_sync. Only q_sync is ever examined.
- States:
  - IDLE: req_ready=1.
    - Single request: grant it.
    - Both requests in the same cycle: grant the one not granted last. The first conflict after reset grants reset. The loser stays pending because its requester holds it.
    - Accept at edge N with target == q_sync: no pulse. done=1, err=0 in cycle N+1, then stay in IDLE.
    - Otherwise latch the target and go to PULSE.
  - PULSE: the selected latch line is 0 for exactly PULSE_W cycles (N+1..N+PULSE_W). The other line stays 1. Then go to GAP.
  - GAP: both lines are 1 for exactly GAP_W cycles. Then go to CHECK.
  - CHECK: one cycle, at N+PULSE_W+GAP_W+1.
    - done=1; err=(q_sync != target).
    - Go to IDLE; req_ready=1 from N+PULSE_W+GAP_W+2.
- Requests asserted or dropped while busy are ignored. There is no queueing; requesters hold until they see their grant.
- A request dropped before acceptance is simply not granted.
- Reset mid-operation: on the edge where reset0=0, both latch lines go to 1, busy/done/err/grant clear, and the FSM returns to IDLE. No partial pulse is extended. The latch state afterwards is whatever the truncated pulse produced.
- Counters use ceil(log2(15+1))=4 bits and count down from W-1 to 0. Parameters outside their legal range are a configuration error; a simulation $error at time 0 is required.

Test Plan:
- Latch model used: NAND pair with 1-cycle gate delay, q=0 at start. Parameters PULSE_W=3, GAP_W=2, SYNC_STAGES=2.
1. Reset release then set_req at cycle 0 -> latch_set0 low cycles 1-3; both lines high cycles 4-5; done=1, err=0 at cycle 6; req_ready=1 at cycle 7; latch_q=1.
2. With q=1, rst_req -> latch_rst0 low for exactly 3 cycles; done, err=0; latch_q=0.
3. set_req and rst_req held high together from IDLE after reset -> grant_rst first, then grant_set on the next accept. Latch lines are never both 0 (assertion checked every cycle).
4. With q=1, set_req -> done at accept+1 with err=0. Neither latch line toggles.
5. Latch model stuck at q=0, set_req -> done=1 with err=1 at cycle 6.
6. reset0 driven low at cycle 2 of a set pulse -> latch_set0=1 on that edge; busy=0; no done pulse. After release, req_ready=1 and a new set completes with err=0.
